// File: rtl/sdhci_dat_rx.sv
// sdhci_dat_rx -- SD DAT-line receive engine feeding the host read buffer.
//
// Samples lane 0 or all NumLanes DAT lines on each sample_en_i strobe, runs
// multi-block reads (start-bit timeout, per-lane CRC16, end-bit check) and
// packs the byte stream into 32-bit words, first byte in data_o[7:0].
// The SD clock is held off through clk_stop_o so no data is ever dropped.
//
// Ports:
//   clk_i, rst_i                   system clock, async active-high reset
//   sample_en_i, dat_i             SD-clock strobe and synchronised DAT lines
//   wide_bus_i, block_size_i,
//   block_count_i, timeout_i       transfer setup, latched on start_i
//   start_i, stop_i                begin / abort transfer
//   data_o, data_valid_o,
//   data_ready_i                   word output with valid/ready handshake
//   clk_stop_o                     hold request to the SD clock generator
//   busy_o, block_done_o,
//   xfer_done_o                    status and completion pulses
//   crc_err_o, end_bit_err_o,
//   timeout_err_o                  error pulses, coincident with xfer_done_o
//
// Build option: define SDHCI_DAT_RX_CRC_EN to build the CRC16 checkers;
// otherwise the CRC field is consumed unchecked and crc_err_o is tied 0.
module sdhci_dat_rx #(
  parameter int unsigned NumLanes     = 4,
  parameter int unsigned TimeoutWidth = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sample_en_i,
  input  logic [NumLanes-1:0]     dat_i,
  input  logic                    wide_bus_i,
  input  logic [11:0]             block_size_i,
  input  logic [15:0]             block_count_i,
  input  logic [TimeoutWidth-1:0] timeout_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  output logic [31:0]             data_o,
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic                    clk_stop_o,
  output logic                    busy_o,
  output logic                    block_done_o,
  output logic                    xfer_done_o,
  output logic                    crc_err_o,
  output logic                    end_bit_err_o,
  output logic                    timeout_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [5:0] WideSpw = 6'(32 / NumLanes);

  logic [2:0]              state;
  logic                    wide;
  logic [9:0]              wpb;
  logic [15:0]             blk_left;
  logic                    unbounded;
  logic [TimeoutWidth-1:0] tmo_lim;
  logic [TimeoutWidth-1:0] tmo_cnt;
  logic [31:0]             acc;
  logic [5:0]              sc;
  logic [9:0]              wc;
  logic [3:0]              cc;

  logic [NumLanes-1:0]     lane_mask;
  logic [5:0]              spw;
  logic                    last_slot;
  logic                    strobe;
  logic                    all_zero;
  logic                    all_one;
  logic [31:0]             next_acc;
  logic                    crc_fail;
  logic                    unused_bits;

  assign unused_bits = ^block_size_i[1:0];

  always_comb begin
    lane_mask = wide ? '1 : NumLanes'(1);
    spw       = wide ? WideSpw : 6'd32;
    last_slot = (sc == spw - 6'd1);
    all_zero  = ((dat_i & lane_mask) == '0);
    all_one   = ((dat_i | ~lane_mask) == '1);
    next_acc  = wide ? {acc[31-NumLanes:0], dat_i} : {acc[30:0], dat_i[0]};
  end

  // The word-completing strobe is held off while the output register is
  // still full, so a completed word can always be loaded directly.
  assign clk_stop_o = (state == S_DATA) && last_slot && data_valid_o;
  assign strobe     = sample_en_i && !clk_stop_o;
  assign busy_o     = (state != S_IDLE) || data_valid_o;

`ifdef SDHCI_DAT_RX_CRC_EN
  logic [15:0] crc [NumLanes];
  logic        crc_bad;

  // Received CRC bits are compared against the running CRC MSB first by
  // shifting the register out during the CRC field.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumLanes; i++) crc[i] <= '0;
      crc_bad <= 1'b0;
    end else if (strobe) begin
      if (state == S_WAIT) begin
        for (int unsigned i = 0; i < NumLanes; i++) crc[i] <= '0;
        crc_bad <= 1'b0;
      end else if (state == S_DATA) begin
        for (int unsigned i = 0; i < NumLanes; i++)
          crc[i] <= {crc[i][14:0], 1'b0} ^
                    ((crc[i][15] ^ dat_i[i]) ? 16'h1021 : 16'h0000);
      end else if (state == S_CRC) begin
        for (int unsigned i = 0; i < NumLanes; i++) begin
          crc[i] <= {crc[i][14:0], 1'b0};
          if (lane_mask[i] && (dat_i[i] != crc[i][15])) crc_bad <= 1'b1;
        end
      end
    end
  end

  assign crc_fail = crc_bad;
`else
  assign crc_fail = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      wide          <= 1'b0;
      wpb           <= '0;
      blk_left      <= '0;
      unbounded     <= 1'b0;
      tmo_lim       <= '0;
      tmo_cnt       <= '0;
      acc           <= '0;
      sc            <= '0;
      wc            <= '0;
      cc            <= '0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      block_done_o  <= 1'b0;
      xfer_done_o   <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      block_done_o  <= 1'b0;
      xfer_done_o   <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      timeout_err_o <= 1'b0;
      if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;

      if (stop_i) begin
        if (state != S_IDLE) begin
          state       <= S_IDLE;
          xfer_done_o <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !data_valid_o && (block_size_i[11:2] != '0)) begin
              wide      <= wide_bus_i;
              wpb       <= block_size_i[11:2];
              blk_left  <= block_count_i;
              unbounded <= (block_count_i == '0);
              tmo_lim   <= timeout_i;
              tmo_cnt   <= timeout_i;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (strobe) begin
              if (all_zero) begin
                sc    <= '0;
                wc    <= '0;
                state <= S_DATA;
              end else if (tmo_cnt <= TimeoutWidth'(1)) begin
                timeout_err_o <= 1'b1;
                xfer_done_o   <= 1'b1;
                state         <= S_IDLE;
              end else begin
                tmo_cnt <= tmo_cnt - TimeoutWidth'(1);
              end
            end
          end
          S_DATA: begin
            if (strobe) begin
              acc <= next_acc;
              if (last_slot) begin
                sc           <= '0;
                data_o       <= {next_acc[7:0], next_acc[15:8],
                                 next_acc[23:16], next_acc[31:24]};
                data_valid_o <= 1'b1;
                if (wc == wpb - 10'd1) begin
                  cc    <= '0;
                  state <= S_CRC;
                end else begin
                  wc <= wc + 10'd1;
                end
              end else begin
                sc <= sc + 6'd1;
              end
            end
          end
          S_CRC: begin
            if (strobe) begin
              cc <= cc + 4'd1;
              if (cc == 4'd15) state <= S_END;
            end
          end
          S_END: begin
            if (strobe) begin
              if (crc_fail || !all_one) begin
                crc_err_o     <= crc_fail;
                end_bit_err_o <= !all_one;
                xfer_done_o   <= 1'b1;
                state         <= S_IDLE;
              end else begin
                block_done_o <= 1'b1;
                if (!unbounded && (blk_left == 16'd1)) begin
                  // Completion is reported only once the last word has left.
                  if (data_valid_o) begin
                    state <= S_DRAIN;
                  end else begin
                    xfer_done_o <= 1'b1;
                    state       <= S_IDLE;
                  end
                end else begin
                  if (!unbounded) blk_left <= blk_left - 16'd1;
                  tmo_cnt <= tmo_lim;
                  state   <= S_WAIT;
                end
              end
            end
          end
          S_DRAIN: begin
            if (!data_valid_o) begin
              xfer_done_o <= 1'b1;
              state       <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdhci_dat_rx.sv
// Testbench for sdhci_dat_rx: scoreboard of expected words, pulse counters
// and one task per scenario.
module tb_sdhci_dat_rx;
  localparam int NL = 4;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic [NL-1:0] dat = '1;
  logic          wide_bus = 1'b0;
  logic [11:0]   block_size = '0;
  logic [15:0]   block_count = '0;
  logic [TW-1:0] timeout = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   data_o;
  logic          data_valid_o;
  logic          data_ready = 1'b0;
  logic          clk_stop_o, busy_o, block_done_o, xfer_done_o;
  logic          crc_err_o, end_bit_err_o, timeout_err_o;

  always #5 clk = ~clk;

  sdhci_dat_rx #(.NumLanes(NL), .TimeoutWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .dat_i(dat),
    .wide_bus_i(wide_bus), .block_size_i(block_size),
    .block_count_i(block_count), .timeout_i(timeout),
    .start_i(start), .stop_i(stop), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready),
    .clk_stop_o(clk_stop_o), .busy_o(busy_o), .block_done_o(block_done_o),
    .xfer_done_o(xfer_done_o), .crc_err_o(crc_err_o),
    .end_bit_err_o(end_bit_err_o), .timeout_err_o(timeout_err_o)
  );

  logic [31:0] sb_q[$];
  logic [7:0]  tx_bytes[$];
  logic [31:0] mon_exp;
  int total = 0, bad = 0;
  int n_blk = 0, n_xfer = 0, n_crc = 0, n_endb = 0, n_tmo = 0, n_words = 0;
  int hold_ready = 0;
  bit stop_seen = 1'b0;

  // Consumer + monitor: ready is driven on the falling edge, so a word is
  // transferred at the next rising edge exactly when valid && ready here.
  always @(negedge clk) begin
    if (rst) begin
      data_ready = 1'b0;
    end else begin
      if (hold_ready > 0) begin
        data_ready = 1'b0;
        hold_ready--;
      end else begin
        data_ready = ($urandom_range(0, 3) != 0);
      end
      if (clk_stop_o)    stop_seen = 1'b1;
      if (block_done_o)  n_blk++;
      if (xfer_done_o)   n_xfer++;
      if (crc_err_o)     n_crc++;
      if (end_bit_err_o) n_endb++;
      if (timeout_err_o) n_tmo++;
      if (data_valid_o && data_ready) begin
        total++;
        n_words++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL word_unexpected: got %h, expected no word", data_o);
        end else begin
          mon_exp = sb_q.pop_front();
          if (data_o !== mon_exp) begin
            bad++;
            $display("FAIL word_data: got %h want %h", data_o, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  task automatic do_strobe(input logic [NL-1:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    sample_en = 1'b0;
    while (clk_stop_o) begin
      guard++;
      if (guard > 2000) begin
        total++;
        bad++;
        $display("FAIL clk_stop_bound: clk_stop_o still 1 after %0d cycles, want release", guard);
        break;
      end
      @(negedge clk);
    end
    sample_en = 1'b1;
    dat = d;
  endtask

  task automatic release_bus();
    @(negedge clk);
    sample_en = 1'b0;
    dat = '1;
  endtask

  task automatic kick(input bit w, input logic [11:0] sz, input logic [15:0] cnt,
                      input logic [TW-1:0] tmo);
    @(negedge clk);
    wide_bus = w; block_size = sz; block_count = cnt; timeout = tmo;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams one block from tx_bytes: idle strobes, start bit, data, CRC, end bit.
  task automatic send_block(input bit w, input int flip_lane, input int flip_bit,
                            input bit bad_end);
    logic [15:0]   crc [NL];
    logic [NL-1:0] d;
    logic [7:0]    b;
    logic [31:0]   wd;
    int lanes, n;
    lanes = w ? NL : 1;
    n = tx_bytes.size();
    wd = '0;
    for (int j = 0; j < NL; j++) crc[j] = '0;
    do_strobe('1);
    do_strobe('1);
    d = '1;
    if (w) d = '0; else d[0] = 1'b0;
    do_strobe(d);
    for (int k = 0; k < n; k++) begin
      b = tx_bytes[k];
      for (int s = 0; s < 8 / lanes; s++) begin
        d = '1;
        for (int j = 0; j < lanes; j++) d[j] = b[8 - (s + 1) * lanes + j];
        for (int j = 0; j < lanes; j++) crc[j] = crc16_upd(crc[j], d[j]);
        do_strobe(d);
      end
      wd = {b, wd[31:8]};
      if (k % 4 == 3) sb_q.push_back(wd);
    end
    tx_bytes.delete();
    for (int i = 0; i < 16; i++) begin
      d = '1;
      for (int j = 0; j < lanes; j++) begin
        d[j] = crc[j][15 - i];
        if (j == flip_lane && (15 - i) == flip_bit) d[j] = ~d[j];
      end
      do_strobe(d);
    end
    d = '1;
    if (bad_end) d[0] = 1'b0;
    do_strobe(d);
    release_bus();
  endtask

  task automatic wait_done(input int snap, input int budget);
    int c;
    c = 0;
    while (n_xfer <= snap && c < budget) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (n_xfer <= snap) begin
      bad++;
      $display("FAIL xfer_done_wait: no xfer_done_o within %0d cycles, want pulse", budget);
    end
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy_o && c < 3000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy_o=%b want 0", tag, busy_o);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d words outstanding, want 0", tag, sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({data_o, data_valid_o, clk_stop_o, busy_o} !== 35'd0) begin
      bad++;
      $display("FAIL reset_data: data_o=%h valid=%b stop=%b busy=%b want all 0",
               data_o, data_valid_o, clk_stop_o, busy_o);
    end
    total++;
    if ({block_done_o, xfer_done_o, crc_err_o, end_bit_err_o, timeout_err_o} !== 5'd0) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 00000",
               {block_done_o, xfer_done_o, crc_err_o, end_bit_err_o, timeout_err_o});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_cases();
    kick(1'b1, 12'd3, 16'd1, 24'd1000);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL size_zero_start: busy_o=%b want 0", busy_o);
    end
    @(negedge clk);
    block_size = 12'd8; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    total++;
    if ({busy_o, xfer_done_o} !== 2'b00) begin
      bad++;
      $display("FAIL start_stop_idle: busy=%b xfer_done=%b want 00", busy_o, xfer_done_o);
    end
  endtask

  task automatic test_single_lane();
    int sb, sx, sc, se, st;
    sb = n_blk; sx = n_xfer; sc = n_crc; se = n_endb; st = n_tmo;
    tx_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    kick(1'b0, 12'd4, 16'd1, 24'd1000);
    send_block(1'b0, -1, -1, 1'b0);
    wait_done(sx, 500);
    total++;
    if (n_blk - sb != 1) begin
      bad++;
      $display("FAIL single_block_done: got %0d pulses want 1", n_blk - sb);
    end
    total++;
    if ((n_crc - sc) + (n_endb - se) + (n_tmo - st) != 0) begin
      bad++;
      $display("FAIL single_errs: got %0d error pulses want 0", (n_crc - sc) + (n_endb - se) + (n_tmo - st));
    end
    wait_idle("single");
  endtask

  task automatic test_backpressure();
    int sb, sx, sw;
    sb = n_blk; sx = n_xfer; sw = n_words;
    stop_seen = 1'b0;
    hold_ready = 200;
    kick(1'b1, 12'd512, 16'd2, 24'd1000);
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 512; i++) tx_bytes.push_back(8'($urandom));
      send_block(1'b1, -1, -1, 1'b0);
    end
    wait_done(sx, 3000);
    wait_idle("bp");
    total++;
    if (stop_seen !== 1'b1) begin
      bad++;
      $display("FAIL bp_clk_stop: clk_stop_o seen=%b want 1", stop_seen);
    end
    total++;
    if (n_words - sw != 256) begin
      bad++;
      $display("FAIL bp_word_count: got %0d words want 256", n_words - sw);
    end
    total++;
    if (n_blk - sb != 2) begin
      bad++;
      $display("FAIL bp_block_done: got %0d pulses want 2", n_blk - sb);
    end
  endtask

  task automatic test_timeout();
    kick(1'b1, 12'd4, 16'd1, 24'd10);
    for (int i = 0; i < 9; i++) do_strobe('1);
    release_bus();
    total++;
    if ({timeout_err_o, busy_o} !== 2'b01) begin
      bad++;
      $display("FAIL tmo_early: timeout_err=%b busy=%b after 9 strobes want 0,1", timeout_err_o, busy_o);
    end
    do_strobe('1);
    release_bus();
    total++;
    if ({timeout_err_o, xfer_done_o, crc_err_o, end_bit_err_o} !== 4'b1100) begin
      bad++;
      $display("FAIL tmo_pulse: tmo/xfer/crc/end=%b want 1100",
               {timeout_err_o, xfer_done_o, crc_err_o, end_bit_err_o});
    end
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_busy: busy_o=%b want 0", busy_o);
    end
  endtask

  task automatic test_crc_error();
    int sb, sx, sc, se;
    bit crc_on;
    sb = n_blk; sx = n_xfer; sc = n_crc; se = n_endb;
`ifdef SDHCI_DAT_RX_CRC_EN
    crc_on = 1'b1;
`else
    crc_on = 1'b0;
`endif
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'($urandom));
    kick(1'b1, 12'd8, 16'd1, 24'd1000);
    send_block(1'b1, 2, 5, 1'b0);
    wait_done(sx, 500);
    total++;
    if (n_crc - sc != int'(crc_on)) begin
      bad++;
      $display("FAIL crc_flag: got %0d crc_err pulses want %0d", n_crc - sc, int'(crc_on));
    end
    total++;
    if (n_blk - sb != int'(!crc_on) || n_endb != se) begin
      bad++;
      $display("FAIL crc_block_done: block_done=%0d end_err=%0d want %0d,0",
               n_blk - sb, n_endb - se, int'(!crc_on));
    end
    wait_idle("crc");
  endtask

  task automatic test_end_bit();
    int sx, se;
    sx = n_xfer; se = n_endb;
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
    kick(1'b0, 12'd4, 16'd1, 24'd1000);
    send_block(1'b0, -1, -1, 1'b1);
    wait_done(sx, 500);
    total++;
    if (n_endb - se != 1) begin
      bad++;
      $display("FAIL end_bit_flag: got %0d end_bit_err pulses want 1", n_endb - se);
    end
    wait_idle("endbit");
  endtask

  task automatic test_stop();
    int sb;
    sb = n_blk;
    kick(1'b1, 12'd8, 16'd0, 24'd1000);
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 8; i++) tx_bytes.push_back(8'($urandom));
      send_block(1'b1, -1, -1, 1'b0);
    end
    do_strobe('1);
    do_strobe('0);
    for (int i = 0; i < 5; i++) do_strobe(NL'($urandom));
    release_bus();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({xfer_done_o, crc_err_o, end_bit_err_o, timeout_err_o} !== 4'b1000) begin
      bad++;
      $display("FAIL stop_pulse: xfer/crc/end/tmo=%b want 1000",
               {xfer_done_o, crc_err_o, end_bit_err_o, timeout_err_o});
    end
    total++;
    if (n_blk - sb != 3) begin
      bad++;
      $display("FAIL stop_blocks: got %0d block_done want 3", n_blk - sb);
    end
    wait_idle("stop");
  endtask

  task automatic test_reset_mid();
    int sb, sx;
    kick(1'b1, 12'd8, 16'd1, 24'd1000);
    do_strobe('1);
    do_strobe('0);
    for (int i = 0; i < 3; i++) do_strobe(NL'($urandom));
    release_bus();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({data_o, data_valid_o, clk_stop_o, busy_o, xfer_done_o} !== 36'd0) begin
      bad++;
      $display("FAIL reset_mid: data_o=%h valid=%b stop=%b busy=%b xfer=%b want all 0",
               data_o, data_valid_o, clk_stop_o, busy_o, xfer_done_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb = n_blk; sx = n_xfer;
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
    kick(1'b1, 12'd4, 16'd1, 24'd1000);
    send_block(1'b1, -1, -1, 1'b0);
    wait_done(sx, 500);
    total++;
    if (n_blk - sb != 1) begin
      bad++;
      $display("FAIL post_reset_block: got %0d block_done want 1", n_blk - sb);
    end
    wait_idle("post_reset");
  endtask

  initial begin
    test_reset();
    test_idle_cases();
    test_single_lane();
    test_backpressure();
    test_timeout();
    test_crc_error();
    test_end_bit();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
